// File: rtl/traffic_lights_cmd_arbiter.sv
// Command arbiter for one traffic_lights instance: power-up configuration, then
// round-robin between two requesters with validation and minimum command spacing.
// Optional shadow registers of the last issued timings: TRAFFIC_LIGHTS_CMD_SHADOW_EN.
module traffic_lights_cmd_arbiter #(
  parameter int CMD_GAP_TICKS  = 3,
  parameter int BOOT_SEQ       = 1,
  parameter int BOOT_GREEN_MS  = 10,
  parameter int BOOT_RED_MS    = 10,
  parameter int BOOT_YELLOW_MS = 10
) (
  input  logic        clk_0m002,
  input  logic        srst_i,
  input  logic [2:0]  req0_type_i,
  input  logic [15:0] req0_data_i,
  input  logic        req0_val_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req1_type_i,
  input  logic [15:0] req1_data_i,
  input  logic        req1_val_i,
  output logic        req1_ready_o,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_val_o,
  output logic [15:0] cmd_data_o,
  output logic        err_o,
  output logic        err_src_o,
  output logic        busy_o,
  output logic        boot_done_o,
  output logic [15:0] green_ms_o,
  output logic [15:0] red_ms_o,
  output logic [15:0] yellow_ms_o
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_GAP} state_t;

  localparam logic [2:0] CMD_ON     = 3'd0;
  localparam logic [2:0] CMD_UNREG  = 3'd2;
  localparam logic [2:0] CMD_GREEN  = 3'd3;
  localparam logic [2:0] CMD_RED    = 3'd4;
  localparam logic [2:0] CMD_YELLOW = 3'd5;

  localparam int            GW        = (CMD_GAP_TICKS > 1) ? $clog2(CMD_GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(CMD_GAP_TICKS - 1);
  localparam logic [2:0]    BOOT_LAST = 3'd4;
  localparam state_t        RST_STATE = (BOOT_SEQ != 0) ? S_BOOT : S_IDLE;

  state_t        state, state_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic [2:0]    boot_idx, boot_idx_next;
  logic          ptr, ptr_next;
  logic          boot_done_next;

  logic          grant0, grant1, sel, fire, cmd_ok;
  logic [2:0]    sel_type;
  logic [15:0]   sel_data;
  logic          issue, reject;
  logic [2:0]    issue_type;
  logic [15:0]   issue_data;

  // Arbitration: the pointer breaks ties only when both requesters are valid.
  assign grant0   = req0_val_i && (!req1_val_i || !ptr);
  assign grant1   = req1_val_i && (!req0_val_i ||  ptr);
  assign sel      = grant1;
  assign sel_type = sel ? req1_type_i : req0_type_i;
  assign sel_data = sel ? req1_data_i : req0_data_i;
  assign fire     = (state == S_IDLE) && (grant0 || grant1);
  assign cmd_ok   = (sel_type <= CMD_UNREG) ||
                    ((sel_type <= CMD_YELLOW) && (sel_data != 16'd0));

  // Reset gates the combinational outputs so every output reads 0 during reset.
  assign req0_ready_o = (state == S_IDLE) && grant0 && !srst_i;
  assign req1_ready_o = (state == S_IDLE) && grant1 && !srst_i;
  assign busy_o       = (state != S_IDLE) && !srst_i;

  // NOTE: every always_comb target is given a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    gap_cnt_next   = gap_cnt;
    boot_idx_next  = boot_idx;
    ptr_next       = ptr;
    boot_done_next = boot_done_o || (BOOT_SEQ == 0);
    issue          = 1'b0;
    reject         = 1'b0;
    issue_type     = sel_type;
    issue_data     = (sel_type >= CMD_GREEN) ? sel_data : 16'd0;

    case (state)
      S_BOOT: begin
        issue        = 1'b1;
        state_next   = S_GAP;
        gap_cnt_next = '0;
        case (boot_idx)
          3'd0:    begin issue_type = CMD_UNREG;  issue_data = 16'd0;                 end
          3'd1:    begin issue_type = CMD_GREEN;  issue_data = 16'(BOOT_GREEN_MS);    end
          3'd2:    begin issue_type = CMD_RED;    issue_data = 16'(BOOT_RED_MS);      end
          3'd3:    begin issue_type = CMD_YELLOW; issue_data = 16'(BOOT_YELLOW_MS);   end
          default: begin issue_type = CMD_ON;     issue_data = 16'd0;                 end
        endcase
      end
      S_IDLE: begin
        if (fire) begin
          ptr_next = ~sel;
          if (cmd_ok) begin
            issue        = 1'b1;
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (boot_done_o) begin
            state_next = S_IDLE;
          end else if (boot_idx == BOOT_LAST) begin
            state_next     = S_IDLE;
            boot_done_next = 1'b1;
          end else begin
            boot_idx_next = boot_idx + 3'd1;
            state_next    = S_BOOT;
          end
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      default: state_next = RST_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_0m002 or posedge srst_i) begin
    if (srst_i) begin
      state       <= RST_STATE;
      gap_cnt     <= '0;
      boot_idx    <= '0;
      ptr         <= 1'b0;
      boot_done_o <= 1'b0;
      cmd_val_o   <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      err_o       <= 1'b0;
      err_src_o   <= 1'b0;
    end else begin
      state       <= state_next;
      gap_cnt     <= gap_cnt_next;
      boot_idx    <= boot_idx_next;
      ptr         <= ptr_next;
      boot_done_o <= boot_done_next;
      cmd_val_o   <= issue;
      err_o       <= reject;
      if (issue) begin
        cmd_type_o <= issue_type;
        cmd_data_o <= issue_data;
      end
      if (reject) err_src_o <= sel;
    end
  end

`ifdef TRAFFIC_LIGHTS_CMD_SHADOW_EN
  always_ff @(posedge clk_0m002 or posedge srst_i) begin
    if (srst_i) begin
      green_ms_o  <= '0;
      red_ms_o    <= '0;
      yellow_ms_o <= '0;
    end else if (issue) begin
      case (issue_type)
        CMD_GREEN:  green_ms_o  <= issue_data;
        CMD_RED:    red_ms_o    <= issue_data;
        CMD_YELLOW: yellow_ms_o <= issue_data;
        default: ;
      endcase
    end
  end
`else
  assign green_ms_o  = '0;
  assign red_ms_o    = '0;
  assign yellow_ms_o = '0;
`endif

endmodule

// File: tb/tb_traffic_lights_cmd_arbiter.sv
// Directed bench for traffic_lights_cmd_arbiter with default parameters
// (gap 3, boot enabled, boot timings 10); shadow expectations follow the macro.
module tb_traffic_lights_cmd_arbiter;

`ifdef TRAFFIC_LIGHTS_CMD_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  r0_type, r1_type;
  logic [15:0] r0_data, r1_data;
  logic        r0_val, r1_val;
  logic        r0_ready, r1_ready;
  logic [2:0]  cmd_type;
  logic        cmd_val;
  logic [15:0] cmd_data;
  logic        err, err_src, busy, boot_done;
  logic [15:0] green_ms, red_ms, yellow_ms;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_lights_cmd_arbiter dut (
    .clk_0m002   (clk),
    .srst_i      (rst),
    .req0_type_i (r0_type),
    .req0_data_i (r0_data),
    .req0_val_i  (r0_val),
    .req0_ready_o(r0_ready),
    .req1_type_i (r1_type),
    .req1_data_i (r1_data),
    .req1_val_i  (r1_val),
    .req1_ready_o(r1_ready),
    .cmd_type_o  (cmd_type),
    .cmd_val_o   (cmd_val),
    .cmd_data_o  (cmd_data),
    .err_o       (err),
    .err_src_o   (err_src),
    .busy_o      (busy),
    .boot_done_o (boot_done),
    .green_ms_o  (green_ms),
    .red_ms_o    (red_ms),
    .yellow_ms_o (yellow_ms)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sh(input logic [15:0] v);
    return SH ? v : 16'd0;
  endfunction

  // Advance one active edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(input logic [2:0] t, input logic [15:0] d, input logic v);
    r0_type = t; r0_data = d; r0_val = v;
  endtask

  task automatic drive1(input logic [2:0] t, input logic [15:0] d, input logic v);
    r1_type = t; r1_data = d; r1_val = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cmd_val"},   cmd_val,   0);
    check({tag, ".cmd_type"},  cmd_type,  0);
    check({tag, ".cmd_data"},  cmd_data,  0);
    check({tag, ".err"},       err,       0);
    check({tag, ".err_src"},   err_src,   0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".boot_done"}, boot_done, 0);
    check({tag, ".ready0"},    r0_ready,  0);
    check({tag, ".ready1"},    r1_ready,  0);
    check({tag, ".green"},     green_ms,  0);
    check({tag, ".red"},       red_ms,    0);
    check({tag, ".yellow"},    yellow_ms, 0);
  endtask

  // Called on the falling edge where reset has just been released.
  task automatic run_boot(input string tag);
    logic [2:0]  exp_type [5];
    logic [15:0] exp_data [5];
    exp_type = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_data = '{16'd0, 16'd10, 16'd10, 16'd10, 16'd0};
    drive0(3'd1, 16'd0, 1'b1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bit exp_v;
      int k;
      step();
      exp_v = (cyc <= 17) && (((cyc - 1) % 4) == 0);
      k     = (cyc - 1) / 4;
      check($sformatf("%s.val%0d", tag, cyc), cmd_val, exp_v);
      if (exp_v) begin
        check($sformatf("%s.type%0d", tag, cyc), cmd_type, exp_type[k]);
        check($sformatf("%s.data%0d", tag, cyc), cmd_data, exp_data[k]);
      end
      check($sformatf("%s.done%0d", tag, cyc), boot_done, cyc >= 20);
      check($sformatf("%s.busy%0d", tag, cyc), busy, cyc < 20);
      if (cyc < 20) check($sformatf("%s.rdy%0d", tag, cyc), r0_ready, 0);
      if (cyc == 19) r0_val = 1'b0;
    end
    check({tag, ".green"},  green_ms,  sh(16'd10));
    check({tag, ".red"},    red_ms,    sh(16'd10));
    check({tag, ".yellow"}, yellow_ms, sh(16'd10));
  endtask

  initial begin
    rst = 1'b1;
    drive0(3'd0, 16'd0, 1'b0);
    drive1(3'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    check_zero("reset");

    // Boot sequence after reset release.
    rst = 1'b0;
    run_boot("boot");

    // Contention: pointer starts at req0, then alternates.
    drive0(3'd4, 16'd7, 1'b1);
    drive1(3'd5, 16'd7, 1'b1);
    #1;
    check("both.rdy0", r0_ready, 1);
    check("both.rdy1", r1_ready, 0);
    step();
    check("both.val_a",  cmd_val,  1);
    check("both.type_a", cmd_type, 4);
    check("both.data_a", cmd_data, 7);
    check("both.red",    red_ms,   sh(16'd7));
    check("both.gap_rdy0", r0_ready, 0);
    check("both.gap_rdy1", r1_ready, 0);
    repeat (2) step();
    check("both.gap_val", cmd_val, 0);
    check("both.gap_busy", busy, 1);
    step();
    check("both.idle_rdy0", r0_ready, 0);
    check("both.idle_rdy1", r1_ready, 1);
    step();
    check("both.val_b",  cmd_val,   1);
    check("both.type_b", cmd_type,  5);
    check("both.yellow", yellow_ms, sh(16'd7));
    repeat (3) step();
    check("both.rdy0_c", r0_ready, 1);
    check("both.rdy1_c", r1_ready, 0);
    step();
    check("both.val_c",  cmd_val,  1);
    check("both.type_c", cmd_type, 4);
    drive0(3'd0, 16'd0, 1'b0);
    drive1(3'd0, 16'd0, 1'b0);
    repeat (3) step();

    // Single GREEN_TIME from req0.
    drive0(3'd3, 16'd25, 1'b1);
    #1;
    check("green.rdy", r0_ready, 1);
    step();
    check("green.val",   cmd_val,  1);
    check("green.type",  cmd_type, 3);
    check("green.data",  cmd_data, 25);
    check("green.shadow", green_ms, sh(16'd25));
    check("green.gap_rdy1", r0_ready, 0);
    step();
    check("green.gap_rdy2", r0_ready, 0);
    check("green.val_off",  cmd_val,  0);
    check("green.data_hold", cmd_data, 25);
    step();
    check("green.gap_rdy3", r0_ready, 0);
    r0_val = 1'b0;
    step();
    check("green.busy", busy, 0);

    // Invalid code from req1, then an immediate OFF from req0.
    drive1(3'd6, 16'd0, 1'b1);
    #1;
    check("bad6.rdy1", r1_ready, 1);
    step();
    check("bad6.val",  cmd_val, 0);
    check("bad6.err",  err,     1);
    check("bad6.src",  err_src, 1);
    check("bad6.busy", busy,    0);
    r1_val = 1'b0;
    drive0(3'd1, 16'h1234, 1'b1);
    #1;
    check("off.rdy0", r0_ready, 1);
    step();
    check("off.err",  err,      0);
    check("off.val",  cmd_val,  1);
    check("off.type", cmd_type, 1);
    check("off.data", cmd_data, 0);
    r0_val = 1'b0;
    repeat (3) step();

    // YELLOW_TIME with zero data is rejected.
    drive0(3'd5, 16'd0, 1'b1);
    #1;
    check("y0.rdy0", r0_ready, 1);
    step();
    check("y0.err",    err,       1);
    check("y0.src",    err_src,   0);
    check("y0.val",    cmd_val,   0);
    check("y0.yellow", yellow_ms, sh(16'd7));
    r0_val = 1'b0;
    step();
    check("y0.err_end", err, 0);

    // Reset while idle, then reset in the GAP after the boot GREEN_TIME.
    rst = 1'b1;
    #1;
    check_zero("rst_idle");
    @(negedge clk);
    rst = 1'b0;
    step();
    check("reboot.val1",  cmd_val,  1);
    check("reboot.type1", cmd_type, 2);
    repeat (4) step();
    check("reboot.val5",  cmd_val,  1);
    check("reboot.type5", cmd_type, 3);
    check("reboot.data5", cmd_data, 10);
    check("reboot.green", green_ms, sh(16'd10));
    rst = 1'b1;
    #1;
    check_zero("rst_gap");
    @(negedge clk);
    rst = 1'b0;
    run_boot("reboot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
